// File: rtl/gpu_pkg.sv
// gpu_pkg -- shared types for the GPU pipeline.
//   lane_t     : one 18-bit datapath lane
//   vec_t      : NLANES lanes moved together
//   wb_entry_t : one write-back queue entry (destination register + data)
// Helpers: reg_onehot (register address to one-hot mask), lane_select
// (per-lane result mux between memory data and ALU output).
package gpu_pkg;

  localparam int NLANES = 3;
  localparam int LANE_W = 18;
  localparam int REG_AW = 4;
  localparam int NREGS  = 16;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [NLANES-1:0] vec_t;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    vec_t              data;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NREGS-1:0] v;
    v    = {NREGS{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  // All lanes switch together: a result is either a load or an ALU value.
  function automatic vec_t lane_select(input logic sel_mem, input vec_t mem_v,
                                       input vec_t alu_v);
    vec_t v;
    for (int l = 0; l < NLANES; l++) begin
      v[l] = sel_mem ? mem_v[l] : alu_v[l];
    end
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- circular write-back queue of DEPTH entries (DEPTH power of two).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_i         : enqueue wdata_i (ignored when full)
//   pop_i          : dequeue head (ignored when empty)
//   wdata_i        : entry to enqueue
//   head_o         : oldest entry
//   count_o        : registered occupancy
//   full_o         : count_o == DEPTH
//   rd_ptr_o       : slot of the oldest entry (age reference for mem_o)
//   mem_o          : raw storage; slot (rd_ptr_o + k) is valid when k < count_o
module wb_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  wb_entry_t     wdata_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic [PW-1:0] rd_ptr_o,
  output wb_entry_t     mem_o [DEPTH]
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & (count_q != {CW{1'b0}});

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register and entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign rd_ptr_o = rd_ptr_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem_out
    assign mem_o[g] = mem_q[g];
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit -- buffers memory-stage results and writes them to the
// Decode register file in acceptance order, one per cycle when the write
// port is free.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ValidM / ReadyM     : result handshake from the memory stage
//   RegWriteM           : result writes a register (0 = accepted and dropped)
//   MemtoRegM           : data select, ReadDataM (1) or ALUOutM (0)
//   WA3M, ALUOutM, ReadDataM : destination and per-lane data candidates
//   RfBusyW             : register-file write port unavailable this cycle
//   RegWriteW, wa3w, wd3: registered write strobe, address, data
//   PendingW            : per-register flag, write queued or on the port
// Optional build macro WB_BYPASS_EN adds ra1D/ra2D and Fwd1*/Fwd2*
// (combinational forwarding of the youngest pending value per register).
module writeback_unit
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  output logic              ReadyM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [REG_AW-1:0] WA3M,
  input  vec_t              ALUOutM,
  input  vec_t              ReadDataM,
  input  logic              RfBusyW,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] wa3w,
  output vec_t              wd3,
  output logic [NREGS-1:0]  PendingW
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  output logic              Fwd1Hit,
  output logic              Fwd2Hit,
  output vec_t              Fwd1Data,
  output vec_t              Fwd2Data
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         entry_s;
  wb_entry_t         head_s;
  wb_entry_t         mem_s [DEPTH];
  logic [CW-1:0]     count_s;
  logic [PW-1:0]     rd_ptr_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;

  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] wa3_q, wa3_d;
  vec_t              wd3_q, wd3_d;
  logic [NREGS-1:0]  pending_s;
  logic [PW-1:0]     idx_s;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle never frees a slot for that cycle's push.
  assign ReadyM = ~full_s;
  assign push_s = ValidM & ~full_s & RegWriteM;
  assign pop_s  = (count_s != {CW{1'b0}}) & ~RfBusyW;

  assign entry_s.addr = WA3M;
  assign entry_s.data = lane_select(MemtoRegM, ReadDataM, ALUOutM);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .wdata_i  (entry_s),
    .head_o   (head_s),
    .count_o  (count_s),
    .full_o   (full_s),
    .rd_ptr_o (rd_ptr_s),
    .mem_o    (mem_s)
  );

  // Write-port next state: load head on pop, otherwise drop strobe and hold.
  always_comb begin
    regwrite_d = 1'b0;
    wa3_d      = wa3_q;
    wd3_d      = wd3_q;
    if (pop_s) begin
      regwrite_d = 1'b1;
      wa3_d      = head_s.addr;
      wd3_d      = head_s.data;
    end else begin
      regwrite_d = 1'b0;
    end
  end

  // Write-port output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wa3_q      <= {REG_AW{1'b0}};
      wd3_q      <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
    end
  end

  assign RegWriteW = regwrite_q;
  assign wa3w      = wa3_q;
  assign wd3       = wd3_q;

  // Pending mask: the live output plus every occupied queue slot.
  always_comb begin
    pending_s = regwrite_q ? reg_onehot(wa3_q) : {NREGS{1'b0}};
    idx_s     = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx_s     = rd_ptr_s + PW'(k);
      pending_s = pending_s |
                  ((CW'(k) < count_s) ? reg_onehot(mem_s[idx_s].addr) : {NREGS{1'b0}});
    end
  end

  assign PendingW = pending_s;

`ifdef WB_BYPASS_EN
  logic [REG_AW-1:0] ra_s    [2];
  logic              fhit_s  [2];
  vec_t              fdata_s [2];
  logic [PW-1:0]     fidx_s;
  logic              fmatch_s;

  assign ra_s[0] = ra1D;
  assign ra_s[1] = ra2D;

  // Forwarding search, oldest first (output register, then queue head to
  // tail) so the last match seen is the youngest value.
  always_comb begin
    fidx_s   = {PW{1'b0}};
    fmatch_s = 1'b0;
    for (int p = 0; p < 2; p++) begin
      fhit_s[p]  = 1'b0;
      fdata_s[p] = '0;
      fmatch_s   = regwrite_q & (wa3_q == ra_s[p]);
      fhit_s[p]  = fhit_s[p] | fmatch_s;
      fdata_s[p] = fmatch_s ? wd3_q : fdata_s[p];
      for (int k = 0; k < DEPTH; k++) begin
        fidx_s     = rd_ptr_s + PW'(k);
        fmatch_s   = (CW'(k) < count_s) & (mem_s[fidx_s].addr == ra_s[p]);
        fhit_s[p]  = fhit_s[p] | fmatch_s;
        fdata_s[p] = fmatch_s ? mem_s[fidx_s].data : fdata_s[p];
      end
    end
  end

  assign Fwd1Hit  = fhit_s[0];
  assign Fwd2Hit  = fhit_s[1];
  assign Fwd1Data = fdata_s[0];
  assign Fwd2Data = fdata_s[1];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit -- directed, table-driven bench for writeback_unit
// (DEPTH=4), plus hand-written sequences for back-pressure, reset and,
// when WB_BYPASS_EN is defined, forwarding.
module tb_writeback_unit;
  import gpu_pkg::*;

  logic              clk;
  logic              rst;
  logic              ValidM;
  logic              ReadyM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic [REG_AW-1:0] WA3M;
  vec_t              ALUOutM;
  vec_t              ReadDataM;
  logic              RfBusyW;
  logic              RegWriteW;
  logic [REG_AW-1:0] wa3w;
  vec_t              wd3;
  logic [NREGS-1:0]  PendingW;
`ifdef WB_BYPASS_EN
  logic [REG_AW-1:0] ra1D, ra2D;
  logic              Fwd1Hit, Fwd2Hit;
  vec_t              Fwd1Data, Fwd2Data;
`endif

  writeback_unit #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ValidM    (ValidM),
    .ReadyM    (ReadyM),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .WA3M      (WA3M),
    .ALUOutM   (ALUOutM),
    .ReadDataM (ReadDataM),
    .RfBusyW   (RfBusyW),
    .RegWriteW (RegWriteW),
    .wa3w      (wa3w),
    .wd3       (wd3),
    .PendingW  (PendingW)
`ifdef WB_BYPASS_EN
    ,
    .ra1D      (ra1D),
    .ra2D      (ra2D),
    .Fwd1Hit   (Fwd1Hit),
    .Fwd2Hit   (Fwd2Hit),
    .Fwd1Data  (Fwd1Data),
    .Fwd2Data  (Fwd2Data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [3:0]  wa;
    logic [53:0] alu;
    logic [53:0] rdd;
    logic        busy;
    logic        exp_rw;
    logic [3:0]  exp_wa;
    logic [53:0] exp_wd;
    logic [15:0] exp_pend;
    logic        exp_ready;
  } vec_rec_t;

  localparam int NVEC = 12;
  vec_rec_t tbl [NVEC];

  int checks;
  int errors;

  logic [53:0] va, vb, vc, vd, z54, vk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ValidM    = 1'b0;
    RegWriteM = 1'b0;
    MemtoRegM = 1'b0;
    WA3M      = 4'd0;
    ALUOutM   = '0;
    ReadDataM = '0;
  endtask

  task automatic push(input logic [3:0] wa, input logic [53:0] d);
    ValidM    = 1'b1;
    RegWriteM = 1'b1;
    MemtoRegM = 1'b0;
    WA3M      = wa;
    ALUOutM   = d;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    va  = {18'h20000, 18'h3FFFF, 18'h2AAAA};
    vb  = {18'h2A802, 18'h381FF, 18'h2BFFA};
    vc  = {18'h00001, 18'h00002, 18'h00003};
    vd  = {18'h15555, 18'h0F0F0, 18'h3C3C3};
    z54 = 54'd0;

    // valid rw m2r wa alu rdd busy | exp_rw exp_wa exp_wd exp_pend exp_ready
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'd1, va,  z54, 1'b0, 1'b0, 4'd0, z54, 16'h0002, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, z54, z54, 1'b0, 1'b1, 4'd1, va,  16'h0002, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, z54, z54, 1'b0, 1'b0, 4'd1, va,  16'h0000, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'd3, va,  vb,  1'b0, 1'b0, 4'd1, va,  16'h0008, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, z54, z54, 1'b0, 1'b1, 4'd3, vb,  16'h0008, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, z54, z54, 1'b0, 1'b0, 4'd3, vb,  16'h0000, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'd5, va,  z54, 1'b0, 1'b0, 4'd3, vb,  16'h0000, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, z54, z54, 1'b0, 1'b0, 4'd3, vb,  16'h0000, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'd2, vc,  z54, 1'b0, 1'b0, 4'd3, vb,  16'h0004, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd4, vd,  z54, 1'b0, 1'b1, 4'd2, vc,  16'h0014, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0, z54, z54, 1'b0, 1'b1, 4'd4, vd,  16'h0010, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0, z54, z54, 1'b0, 1'b0, 4'd4, vd,  16'h0000, 1'b1};

    rst     = 1'b1;
    RfBusyW = 1'b0;
    idle_inputs();
`ifdef WB_BYPASS_EN
    ra1D = 4'd0;
    ra2D = 4'd0;
`endif
    tick();
    tick();
    rst = 1'b0;

    chk("reset ReadyM",    64'(ReadyM),    64'd1);
    chk("reset RegWriteW", 64'(RegWriteW), 64'd0);
    chk("reset wa3w",      64'(wa3w),      64'd0);
    chk("reset wd3",       64'(wd3),       64'd0);
    chk("reset PendingW",  64'(PendingW),  64'd0);

    for (int i = 0; i < NVEC; i++) begin
      ValidM    = tbl[i].valid;
      RegWriteM = tbl[i].rw;
      MemtoRegM = tbl[i].m2r;
      WA3M      = tbl[i].wa;
      ALUOutM   = tbl[i].alu;
      ReadDataM = tbl[i].rdd;
      RfBusyW   = tbl[i].busy;
      tick();
      chk($sformatf("vec%0d RegWriteW", i), 64'(RegWriteW), 64'(tbl[i].exp_rw));
      chk($sformatf("vec%0d wa3w", i),      64'(wa3w),      64'(tbl[i].exp_wa));
      chk($sformatf("vec%0d wd3", i),       64'(wd3),       64'(tbl[i].exp_wd));
      chk($sformatf("vec%0d PendingW", i),  64'(PendingW),  64'(tbl[i].exp_pend));
      chk($sformatf("vec%0d ReadyM", i),    64'(ReadyM),    64'(tbl[i].exp_ready));
    end

    // Back-pressure: fill the queue while the write port is busy.
    RfBusyW = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vk = {18'(k), 18'(k + 16), 18'(k + 32)};
      push(4'(2 * k + 1), vk);
      chk($sformatf("fill%0d ReadyM", k), 64'(ReadyM), (k < 3) ? 64'd1 : 64'd0);
      chk($sformatf("fill%0d RegWriteW", k), 64'(RegWriteW), 64'd0);
    end
    chk("full PendingW", 64'(PendingW), 64'h00AA);
    // Push attempt against a full queue must be refused.
    push(4'd9, vd);
    chk("blocked ReadyM",   64'(ReadyM),   64'd0);
    chk("blocked PendingW", 64'(PendingW), 64'h00AA);
    idle_inputs();
    RfBusyW = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vk = {18'(k), 18'(k + 16), 18'(k + 32)};
      tick();
      chk($sformatf("drain%0d RegWriteW", k), 64'(RegWriteW), 64'd1);
      chk($sformatf("drain%0d wa3w", k),      64'(wa3w),      64'(2 * k + 1));
      chk($sformatf("drain%0d wd3", k),       64'(wd3),       64'(vk));
      chk($sformatf("drain%0d ReadyM", k),    64'(ReadyM),    64'd1);
    end
    tick();
    chk("drained RegWriteW", 64'(RegWriteW), 64'd0);
    chk("drained PendingW",  64'(PendingW),  64'd0);

    // Reset mid-operation with three entries queued and a push presented.
    RfBusyW = 1'b1;
    push(4'd2, va);
    push(4'd4, vb);
    push(4'd6, vc);
    chk("prereset PendingW", 64'(PendingW), 64'h0054);
    rst  = 1'b1;
    WA3M = 4'd8;
    tick();
    rst = 1'b0;
    idle_inputs();
    RfBusyW = 1'b0;
    chk("midrst RegWriteW", 64'(RegWriteW), 64'd0);
    chk("midrst PendingW",  64'(PendingW),  64'd0);
    chk("midrst ReadyM",    64'(ReadyM),    64'd1);
    chk("midrst wa3w",      64'(wa3w),      64'd0);
    chk("midrst wd3",       64'(wd3),       64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("postrst%0d RegWriteW", k), 64'(RegWriteW), 64'd0);
      chk($sformatf("postrst%0d PendingW", k),  64'(PendingW),  64'd0);
    end

`ifdef WB_BYPASS_EN
    // Two writes to r2: forwarding must return the younger one.
    RfBusyW = 1'b1;
    push(4'd2, va);
    push(4'd2, vb);
    idle_inputs();
    ra1D = 4'd2;
    ra2D = 4'd4;
    #1;
    chk("fwd Fwd1Hit",  64'(Fwd1Hit),  64'd1);
    chk("fwd Fwd1Data", 64'(Fwd1Data), 64'(vb));
    chk("fwd Fwd2Hit",  64'(Fwd2Hit),  64'd0);
    chk("fwd Fwd2Data", 64'(Fwd2Data), 64'd0);
    RfBusyW = 1'b0;
    tick();
    chk("fwd pop1 wd3",      64'(wd3),      64'(va));
    chk("fwd pop1 Fwd1Data", 64'(Fwd1Data), 64'(vb));
    tick();
    chk("fwd pop2 wd3",      64'(wd3),      64'(vb));
    chk("fwd pop2 Fwd1Hit",  64'(Fwd1Hit),  64'd1);
    chk("fwd pop2 Fwd1Data", 64'(Fwd1Data), 64'(vb));
    tick();
    chk("fwd done Fwd1Hit",  64'(Fwd1Hit),  64'd0);
    chk("fwd done Fwd1Data", 64'(Fwd1Data), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
